// File: rtl/core_pkg.sv
// Shared encodings for the execute stage: ALU functions, branch conditions,
// multiply/divide opcodes and the divider state machine.
package core_pkg;

  // ALU encoding follows {funct7[5], funct3} of the RV32I OP group
  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSll  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluSrl  = 4'b0101,
    AluOr   = 4'b0110,
    AluAnd  = 4'b0111,
    AluSub  = 4'b1000,
    AluSra  = 4'b1101
  } alu_fn_e;

  typedef enum logic [2:0] {
    BrEq  = 3'b000,
    BrNe  = 3'b001,
    BrLt  = 3'b100,
    BrGe  = 3'b101,
    BrLtu = 3'b110,
    BrGeu = 3'b111
  } br_fn_e;

  typedef enum logic [3:0] {
    MdNone   = 4'd0,
    MdMul    = 4'd1,
    MdMulh   = 4'd2,
    MdMulhsu = 4'd3,
    MdMulhu  = 4'd4,
    MdDiv    = 4'd5,
    MdDivu   = 4'd6,
    MdRem    = 4'd7,
    MdRemu   = 4'd8
  } muldiv_op_e;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  function automatic logic is_div_op(logic [3:0] op);
    return (op == MdDiv) || (op == MdDivu) || (op == MdRem) || (op == MdRemu);
  endfunction

  function automatic logic is_mul_op(logic [3:0] op);
    return (op == MdMul) || (op == MdMulh) || (op == MdMulhsu) || (op == MdMulhu);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per cycle, with start/busy/done
// handshake. Signed operations divide magnitudes and fix signs in DONE.
module div_unit
  import core_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic            abort,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(DIV_ITER + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_ITER - 1);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic            zero_q, zero_d;
  logic            rem_sel_q, rem_sel_d;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign a_mag   = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign b_mag   = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    dvd_d     = dvd_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    zero_d    = zero_q;
    rem_sel_d = rem_sel_q;
    case (state_q)
      DivIdle: begin
        if (start) begin
          state_d   = DivBusy;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = a_mag;
          dsr_d     = b_mag;
          dvd_d     = dividend;
          zero_d    = (divisor == '0);
          quo_neg_d = is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
          rem_neg_d = is_signed && dividend[XLEN-1];
          rem_sel_d = is_rem;
        end
      end
      DivBusy: begin
        if (abort) begin
          state_d = DivIdle;
        end else begin
          // Quotient bits shift in from the right as dividend bits shift out
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = DivDone;
        end
      end
      DivDone: state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= DivIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      dvd_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      dvd_q     <= dvd_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      zero_q    <= zero_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  // MIN/-1 needs no special case: the magnitude quotient negates back to MIN
  always_comb begin
    quo_fix = quo_neg_q ? -quo_q : quo_q;
    rem_fix = rem_neg_q ? -rem_q : rem_q;
    if (zero_q) begin
      quo_fix = '1;
      rem_fix = dvd_q;
    end
    result = rem_sel_q ? rem_fix : quo_fix;
  end

  assign busy = (state_q == DivBusy);
  assign done = (state_q == DivDone);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch/jump resolution, single-cycle multiply and an
// iterative divider that stalls upstream; registers the pipe-5 writeback fields.
module execute_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd4,
  input  logic            we4,
  input  logic [3:0]      alu_fn4,
  input  logic [2:0]      fn4,
  input  logic [XLEN-1:0] B_imm4,
  input  logic [XLEN-1:0] J_imm4,
  input  logic [XLEN-1:0] U_imm4,
  input  logic            btype4,
  input  logic            bneq4,
  input  logic            j4,
  input  logic            jr4,
  input  logic            LUI4,
  input  logic            auipc4,
  input  logic [3:0]      mulDiv_op4,
  input  logic [XLEN-1:0] pc4,
  input  logic            discard,
  output logic            bjtaken,
  output logic [XLEN-1:0] target_pc,
  output logic            div_stall,
  output logic [4:0]      rd5,
  output logic            we5,
  output logic [XLEN-1:0] result5
);

  logic [4:0]        shamt;
  logic [XLEN-1:0]   alu_res;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] product;
  logic              mul_a_sgn;
  logic              mul_b_sgn;
  logic [XLEN-1:0]   exec_res;
  logic              br_cond;
  logic              br_taken;
  logic [XLEN-1:0]   jr_sum;
  logic [XLEN-1:0]   tgt;

  logic              is_div;
  logic              div_busy;
  logic              div_done;
  logic              div_idle;
  logic              div_start;
  logic [XLEN-1:0]   div_result;
  logic [4:0]        div_rd_q;
  logic              div_we_q;

  logic              bj_d;
  logic [XLEN-1:0]   tpc_d;
  logic [4:0]        rd5_d;
  logic              we5_d;
  logic [XLEN-1:0]   res_d;

  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_fn4)
      AluAdd:  alu_res = op_a + op_b;
      AluSub:  alu_res = op_a - op_b;
      AluSll:  alu_res = op_a << shamt;
      AluSlt:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      AluSltu: alu_res = XLEN'(op_a < op_b);
      AluXor:  alu_res = op_a ^ op_b;
      AluSrl:  alu_res = op_a >> shamt;
      AluSra:  alu_res = $signed(op_a) >>> shamt;
      AluOr:   alu_res = op_a | op_b;
      AluAnd:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  // Sign-extend to full product width so one multiplier covers all variants
  assign mul_a_sgn = (mulDiv_op4 == MdMulh) || (mulDiv_op4 == MdMulhsu);
  assign mul_b_sgn = (mulDiv_op4 == MdMulh);
  assign mul_a     = {{XLEN{mul_a_sgn & op_a[XLEN-1]}}, op_a};
  assign mul_b     = {{XLEN{mul_b_sgn & op_b[XLEN-1]}}, op_b};
  assign product   = mul_a * mul_b;

  always_comb begin
    exec_res = alu_res;
    if (LUI4) begin
      exec_res = U_imm4;
    end else if (auipc4) begin
      exec_res = pc4 + U_imm4;
    end else if (j4 || jr4) begin
      exec_res = pc4 + XLEN'(4);
    end else if (is_mul_op(mulDiv_op4)) begin
      exec_res = (mulDiv_op4 == MdMul) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    br_cond = 1'b0;
    case (fn4)
      BrEq:    br_cond = (op_a == op_b);
      BrNe:    br_cond = (op_a != op_b);
      BrLt:    br_cond = ($signed(op_a) < $signed(op_b));
      BrGe:    br_cond = ($signed(op_a) >= $signed(op_b));
      BrLtu:   br_cond = (op_a < op_b);
      BrGeu:   br_cond = (op_a >= op_b);
      default: br_cond = 1'b0;
    endcase
  end

  // bneq4 is a legacy branch-class flag; the condition itself comes from fn4
  assign br_taken = (btype4 || bneq4) && br_cond;
  assign jr_sum   = op_a + op_b;

  always_comb begin
    tgt = '0;
    if (jr4) begin
      tgt = {jr_sum[XLEN-1:1], 1'b0};
    end else if (j4) begin
      tgt = pc4 + J_imm4;
    end else if (br_taken) begin
      tgt = pc4 + B_imm4;
    end
  end

  assign is_div    = is_div_op(mulDiv_op4);
  assign div_idle  = !div_busy && !div_done;
  assign div_start = is_div && div_idle && !discard;
  assign div_stall = div_start || div_busy;

  div_unit #(
    .XLEN     (XLEN),
    .DIV_ITER (DIV_ITER)
  ) u_div_unit (
    .clk       (clk),
    .nrst      (nrst),
    .start     (div_start),
    .abort     (discard),
    .is_signed ((mulDiv_op4 == MdDiv) || (mulDiv_op4 == MdRem)),
    .is_rem    ((mulDiv_op4 == MdRem) || (mulDiv_op4 == MdRemu)),
    .dividend  (op_a),
    .divisor   (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  // Priority: discard, then divider completion, then stall bubble, then new instruction
  always_comb begin
    bj_d  = 1'b0;
    tpc_d = '0;
    rd5_d = '0;
    we5_d = 1'b0;
    res_d = '0;
    if (discard) begin
      bj_d = 1'b0;
    end else if (div_done) begin
      rd5_d = div_rd_q;
      we5_d = div_we_q;
      res_d = div_result;
    end else if (!div_stall) begin
      bj_d  = br_taken || j4 || jr4;
      tpc_d = tgt;
      rd5_d = rd4;
      we5_d = we4 && (rd4 != 5'd0);
      res_d = exec_res;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      bjtaken   <= 1'b0;
      target_pc <= '0;
      rd5       <= '0;
      we5       <= 1'b0;
      result5   <= '0;
      div_rd_q  <= '0;
      div_we_q  <= 1'b0;
    end else begin
      bjtaken   <= bj_d;
      target_pc <= tpc_d;
      rd5       <= rd5_d;
      we5       <= we5_d;
      result5   <= res_d;
      if (div_start) begin
        div_rd_q <= rd4;
        div_we_q <= we4 && (rd4 != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: each driven cycle queues the expected
// pipe-5 outputs; a monitor pops and compares one entry per clock.
module tb_execute_stage;
  import core_pkg::*;

  localparam int unsigned DivIter = 32;

  typedef struct packed {
    logic        bj;
    logic [31:0] tpc;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] res;
  } exp_t;

  localparam exp_t Bubble = '0;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] op_a, op_b, B_imm4, J_imm4, U_imm4, pc4;
  logic [4:0]  rd4;
  logic        we4, btype4, bneq4, j4, jr4, LUI4, auipc4, discard;
  logic [3:0]  alu_fn4, mulDiv_op4;
  logic [2:0]  fn4;
  logic        bjtaken, div_stall, we5;
  logic [31:0] target_pc, result5;
  logic [4:0]  rd5;

  int checks = 0;
  int errors = 0;
  exp_t  exp_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  execute_stage #(
    .XLEN     (32),
    .DIV_ITER (DivIter)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .op_a       (op_a),
    .op_b       (op_b),
    .rd4        (rd4),
    .we4        (we4),
    .alu_fn4    (alu_fn4),
    .fn4        (fn4),
    .B_imm4     (B_imm4),
    .J_imm4     (J_imm4),
    .U_imm4     (U_imm4),
    .btype4     (btype4),
    .bneq4      (bneq4),
    .j4         (j4),
    .jr4        (jr4),
    .LUI4       (LUI4),
    .auipc4     (auipc4),
    .mulDiv_op4 (mulDiv_op4),
    .pc4        (pc4),
    .discard    (discard),
    .bjtaken    (bjtaken),
    .target_pc  (target_pc),
    .div_stall  (div_stall),
    .rd5        (rd5),
    .we5        (we5),
    .result5    (result5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic bj, logic [31:0] tpc, logic [4:0] rd, logic we,
                              logic [31:0] res);
    exp_t e;
    e.bj = bj; e.tpc = tpc; e.rd = rd; e.we = we; e.res = res;
    return e;
  endfunction

  // Monitor: outputs registered at this edge belong to the oldest queued entry
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk({n, " bjtaken"},   {31'b0, bjtaken}, {31'b0, e.bj});
        chk({n, " target_pc"}, target_pc,        e.tpc);
        chk({n, " rd5"},       {27'b0, rd5},     {27'b0, e.rd});
        chk({n, " we5"},       {31'b0, we5},     {31'b0, e.we});
        chk({n, " result5"},   result5,          e.res);
      end
    end
  end

  task automatic clr();
    op_a = '0; op_b = '0; rd4 = '0; we4 = 1'b0; alu_fn4 = AluAdd; fn4 = '0;
    B_imm4 = '0; J_imm4 = '0; U_imm4 = '0; btype4 = 1'b0; bneq4 = 1'b0;
    j4 = 1'b0; jr4 = 1'b0; LUI4 = 1'b0; auipc4 = 1'b0; mulDiv_op4 = MdNone;
    pc4 = '0; discard = 1'b0;
  endtask

  // Inputs already driven; check the combinational stall, queue next-cycle outputs
  task automatic step(input exp_t e, input logic stall_exp, input string nm);
    #1;
    chk({nm, " div_stall"}, {31'b0, div_stall}, {31'b0, stall_exp});
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  task automatic alu(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] res, input string nm);
    clr(); alu_fn4 = fn; op_a = a; op_b = b; rd4 = rd; we4 = 1'b1;
    step(mk(1'b0, 32'h0, rd, rd != 5'd0, res), 1'b0, nm);
  endtask

  task automatic br(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic [31:0] imm, input logic tk,
                    input logic [31:0] tpc, input logic [31:0] res, input string nm);
    clr(); btype4 = 1'b1; fn4 = fn; op_a = a; op_b = b; pc4 = pc; B_imm4 = imm;
    step(mk(tk, tk ? tpc : 32'h0, 5'd0, 1'b0, res), 1'b0, nm);
  endtask

  task automatic mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input string nm);
    clr(); mulDiv_op4 = op; op_a = a; op_b = b; rd4 = 5'd7; we4 = 1'b1;
    step(mk(1'b0, 32'h0, 5'd7, 1'b1, res), 1'b0, nm);
  endtask

  task automatic div_setup(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    clr(); mulDiv_op4 = op; op_a = a; op_b = b; rd4 = rd; we4 = 1'b1;
  endtask

  task automatic div_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input string nm);
    div_setup(op, a, b, rd);
    step(Bubble, 1'b1, {nm, " accept"});
    for (int i = 0; i < DivIter; i++) step(Bubble, 1'b1, {nm, " busy"});
    step(mk(1'b0, 32'h0, rd, 1'b1, res), 1'b0, {nm, " done"});
    clr();
    step(Bubble, 1'b0, {nm, " after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    step(Bubble, 1'b0, "reset");
    nrst = 1'b0;

    alu(AluAdd,  32'd5,        32'hFFFFFFFD, 5'd3, 32'd2,        "add");
    alu(AluSub,  32'd10,       32'd3,        5'd4, 32'd7,        "sub");
    alu(AluSll,  32'd1,        32'h24,       5'd5, 32'h10,       "sll");
    alu(AluSrl,  32'h80000000, 32'd4,        5'd6, 32'h08000000, "srl");
    alu(AluSra,  32'h80000000, 32'd4,        5'd6, 32'hF8000000, "sra");
    alu(AluSlt,  32'hFFFFFFFF, 32'd1,        5'd8, 32'd1,        "slt");
    alu(AluSltu, 32'hFFFFFFFF, 32'd1,        5'd8, 32'd0,        "sltu");
    alu(AluXor,  32'hF0F0,     32'hFF00,     5'd9, 32'h0FF0,     "xor");
    alu(AluOr,   32'hF0F0,     32'hFF00,     5'd9, 32'hFFF0,     "or");
    alu(AluAnd,  32'hF0F0,     32'hFF00,     5'd9, 32'hF000,     "and");
    alu(AluAdd,  32'd1,        32'd1,        5'd0, 32'd2,        "rd0 no write");

    br(BrLt,  32'hFFFFFFFF, 32'd1, 32'h100, 32'h20,       1'b1, 32'h120, 32'h0, "blt");
    br(BrLtu, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20,       1'b0, 32'h0,   32'h0, "bltu");
    br(BrGe,  32'hFFFFFFFF, 32'd1, 32'h100, 32'h20,       1'b0, 32'h0,   32'h0, "bge");
    br(BrGeu, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20,       1'b1, 32'h120, 32'h0, "bgeu");
    br(BrEq,  32'd5,        32'd5, 32'h400, 32'hFFFFFFF0, 1'b1, 32'h3F0, 32'hA, "beq");
    br(BrNe,  32'd5,        32'd5, 32'h400, 32'hFFFFFFF0, 1'b0, 32'h0,   32'hA, "bne");

    clr(); j4 = 1'b1; pc4 = 32'h200; J_imm4 = 32'h40; rd4 = 5'd1; we4 = 1'b1;
    step(mk(1'b1, 32'h240, 5'd1, 1'b1, 32'h204), 1'b0, "jal");
    clr(); LUI4 = 1'b1; U_imm4 = 32'h12345000; rd4 = 5'd2; we4 = 1'b1;
    step(mk(1'b0, 32'h0, 5'd2, 1'b1, 32'h12345000), 1'b0, "lui");
    clr(); auipc4 = 1'b1; pc4 = 32'h1000; U_imm4 = 32'h2000; rd4 = 5'd2; we4 = 1'b1;
    step(mk(1'b0, 32'h0, 5'd2, 1'b1, 32'h3000), 1'b0, "auipc");

    mul(MdMul,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul");
    mul(MdMulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh");
    mul(MdMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    mul(MdMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");

    div_run(MdDiv,  32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, "div -7/2");
    div_run(MdRem,  32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, "rem -7/2");
    div_run(MdDivu, 32'd100,      32'd7,        5'd12, 32'd14,       "divu 100/7");
    div_run(MdRemu, 32'd100,      32'd7,        5'd12, 32'd2,        "remu 100/7");
    div_run(MdDivu, 32'h1234,     32'd0,        5'd13, 32'hFFFFFFFF, "divu by 0");
    div_run(MdRemu, 32'h1234,     32'd0,        5'd13, 32'h1234,     "remu by 0");
    div_run(MdDiv,  32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFFF, "div -7 by 0");
    div_run(MdRem,  32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFF9, "rem -7 by 0");
    div_run(MdDiv,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, "div overflow");
    div_run(MdRem,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h0,        "rem overflow");

    // Abort in the fifth BUSY cycle, then an ADD must complete normally
    div_setup(MdDiv, 32'd1000, 32'd3, 5'd15);
    step(Bubble, 1'b1, "abort accept");
    for (int i = 0; i < 4; i++) step(Bubble, 1'b1, "abort busy");
    discard = 1'b1;
    step(Bubble, 1'b1, "abort discard");
    alu(AluAdd, 32'd5, 32'hFFFFFFFD, 5'd3, 32'd2, "add after abort");

    // Discard in DONE wins over completion
    div_setup(MdDivu, 32'd50, 32'd5, 5'd16);
    step(Bubble, 1'b1, "done-discard accept");
    for (int i = 0; i < DivIter; i++) step(Bubble, 1'b1, "done-discard busy");
    discard = 1'b1;
    step(Bubble, 1'b0, "done-discard drop");
    clr();
    step(Bubble, 1'b0, "done-discard after");

    clr(); discard = 1'b1; alu_fn4 = AluAdd; op_a = 32'd9; op_b = 32'd9; rd4 = 5'd5;
    we4 = 1'b1; j4 = 1'b1; pc4 = 32'h80; J_imm4 = 32'h8;
    step(Bubble, 1'b0, "discard jal");

    // Synchronous reset mid-divide abandons the operation
    div_setup(MdDivu, 32'd77, 32'd7, 5'd17);
    step(Bubble, 1'b1, "rst accept");
    for (int i = 0; i < 10; i++) step(Bubble, 1'b1, "rst busy");
    nrst = 1'b1;
    step(Bubble, 1'b1, "rst mid-divide");
    nrst = 1'b0;
    clr(); jr4 = 1'b1; op_a = 32'h203; op_b = 32'h0; pc4 = 32'h300; rd4 = 5'd1; we4 = 1'b1;
    step(mk(1'b1, 32'h202, 5'd1, 1'b1, 32'h304), 1'b0, "jalr after reset");
    clr();
    for (int i = 0; i < DivIter + 4; i++) step(Bubble, 1'b0, "idle after reset");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
